hex_scan_disp: RTL

HEX_SCAN_DISP -- requirements
Module: hex_scan_disp

---
 rtl/hex_scan_disp.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/hex_scan_disp.sv
// Multiplexed hex display driver: scans DIGITS active-low digits with a guard gap per slot.
// Loads are double-buffered and swapped in only at frame boundaries. Define HEX_SCAN_LZB_EN for leading-zero blanking.
module hex_scan_disp #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 16
) (
    input  logic                  clk,
    input  logic                  rst_btn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    output logic                  pending,
    output logic [DIGITS-1:0]     anodes,
    output logic [7:0]            segments
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] PRESC_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GUARD_END  = CW'(GUARD);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    typedef struct packed {
        logic [4*DIGITS-1:0] data;
        logic [DIGITS-1:0]   dp;
        logic [DIGITS-1:0]   blank;
    } frame_t;

    logic [CW-1:0] presc;
    logic [IW-1:0] idx;
    logic          slot_end;
    logic          frame_end;
    logic          in_guard;

    frame_t pend_buf;
    frame_t disp;

    logic [3:0]        cur_nib;
    logic              cur_dp;
    logic              cur_blank;
    logic              cur_lz;
    logic [DIGITS-1:0] lz_blank;
    logic [7:0]        seg_next;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            default: glyph = 7'h0E;
        endcase
    endfunction

    assign slot_end  = (presc == PRESC_LAST);
    // With a single digit every slot end is also a frame end.
    assign frame_end = slot_end && (idx == IDX_LAST);
    assign in_guard  = (presc < GUARD_END);

    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            presc <= '0;
            idx   <= '0;
        end else begin
            if (slot_end) begin
                presc <= '0;
                if (idx == IDX_LAST)
                    idx <= '0;
                else
                    idx <= idx + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    // A capture always wins over the boundary clear, so a load on the wrap cycle stays pending.
    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            pending  <= 1'b0;
            pend_buf <= '0;
            disp     <= '{data: '0, dp: '0, blank: '1};
        end else begin
            if (frame_end && pending)
                disp <= pend_buf;
            if (load) begin
                pend_buf <= '{data: data, dp: dp, blank: blank};
                pending  <= 1'b1;
            end else if (frame_end) begin
                pending <= 1'b0;
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        logic higher_zero;
        lz_blank    = '0;
        higher_zero = 1'b1;
`ifdef HEX_SCAN_LZB_EN
        for (int i = DIGITS - 1; i > 0; i--) begin
            higher_zero = higher_zero && (disp.data[4*i +: 4] == 4'h0);
            lz_blank[i] = higher_zero;
        end
`endif
    end

    always_comb begin
        cur_nib   = disp.data[4*idx +: 4];
        cur_dp    = disp.dp[idx];
        cur_blank = disp.blank[idx];
        cur_lz    = lz_blank[idx];
        seg_next  = 8'hFF;
        if (cur_blank)
            seg_next = 8'hFF;
        else if (cur_lz)
            seg_next = {~cur_dp, 7'h7F};
        else
            seg_next = {~cur_dp, glyph(cur_nib)};
    end

    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            anodes   <= '1;
            segments <= 8'hFF;
        end else if (in_guard) begin
            anodes   <= '1;
            segments <= 8'hFF;
        end else begin
            anodes   <= ~(DIGITS'(1) << idx);
            segments <= seg_next;
        end
    end

endmodule
